// File: rtl/arm_pkg.sv
// Shared types and constants for the data-memory SRAM controller.
// The external SRAM is 16 bits wide, so each 32-bit word takes two half-word accesses.
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } sram_state_t;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam logic [31:0] DATA_BASE_DEFAULT = 32'd1024;

endpackage

// File: rtl/sram_phase_timer.sv
// Down-counter that times one SRAM half-access phase.
// Loaded with (cycles - 1) on phase entry; zero marks the last cycle of the phase.
module sram_phase_timer #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sram_controller.sv
// MEM-stage bridge from a 32-bit load/store request to a 16-bit asynchronous SRAM.
// Each access runs IDLE -> LO -> HI -> DONE, stalling the pipeline via ready.
module sram_controller
  import arm_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter logic [31:0] DATA_BASE   = DATA_BASE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_we_n
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] PHASE_LOAD = CW'(WAIT_CYCLES - 1);

  sram_state_t state, state_next;

  logic                   req;
  logic                   accept;
  logic                   timer_load;
  logic                   timer_dec;
  logic                   phase_last;
  logic                   in_access;
  logic                   is_write;
  logic [SRAM_ADDR_W-2:0] word;
  logic [31:0]            wdata_hold;
  logic [31:0]            offset;
  logic                   offset_unused;

  assign req    = wr_en | rd_en;
  assign offset = address - DATA_BASE;
  // Byte-lane and high bits of the offset fall outside the 17-bit word index.
  assign offset_unused = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};

  sram_phase_timer #(
    .WIDTH (CW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (PHASE_LOAD),
    .dec        (timer_dec),
    .zero       (phase_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b1;
    accept     = 1'b0;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept     = 1'b1;
          ready      = 1'b0;
          timer_load = 1'b1;
          state_next = LO;
        end
      end
      LO: begin
        ready = 1'b0;
        if (phase_last) begin
          timer_load = 1'b1;
          state_next = HI;
        end else begin
          timer_dec = 1'b1;
        end
      end
      HI: begin
        ready = 1'b0;
        if (phase_last) begin
          state_next = DONE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request is captured once so the pipeline may change its inputs while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_write   <= 1'b0;
      word       <= '0;
      wdata_hold <= '0;
    end else if (accept) begin
      is_write   <= wr_en;
      word       <= offset[SRAM_ADDR_W:2];
      wdata_hold <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (!is_write && phase_last) begin
      if (state == LO) begin
        rdata[15:0] <= sram_dq_in;
      end else if (state == HI) begin
        rdata[31:16] <= sram_dq_in;
      end
    end
  end

  assign in_access = (state == LO) || (state == HI);

  always_comb begin
    sram_addr   = '0;
    sram_dq_oe  = 1'b0;
    sram_dq_out = '0;
    sram_we_n   = 1'b1;
    if (in_access) begin
      sram_addr = {word, state == HI};
      if (is_write) begin
        sram_dq_oe  = 1'b1;
        sram_dq_out = (state == HI) ? wdata_hold[31:16] : wdata_hold[15:0];
        // Release we_n one cycle early so address and data are held past the write.
        sram_we_n   = phase_last;
      end
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller (WAIT_CYCLES=3) with a tiny behavioural SRAM.
// Checks every cycle of each access plus reset, wrap-around and back-to-back behaviour.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  logic [15:0] mem [0:7];
  int vectors;
  int miscompares;

  sram_controller dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .address     (address),
    .wdata       (wdata),
    .rdata       (rdata),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: only the low three address bits are decoded.
  assign sram_dq_in = mem[sram_addr[2:0]];
  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr[2:0]] <= sram_dq_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Check one cycle's outputs at the falling edge, then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic rdy, input logic [17:0] a,
                     input logic oe, input logic [15:0] dq, input logic wen);
    @(negedge clk);
    chk({tag, ".ready"}, {31'd0, ready}, {31'd0, rdy});
    chk({tag, ".addr"}, {14'd0, sram_addr}, {14'd0, a});
    chk({tag, ".oe"}, {31'd0, sram_dq_oe}, {31'd0, oe});
    chk({tag, ".dq"}, {16'd0, sram_dq_out}, {16'd0, dq});
    chk({tag, ".we_n"}, {31'd0, sram_we_n}, {31'd0, wen});
    $display("%s: ready=%b addr=%h oe=%b dq=%h we_n=%b rdata=%h",
             tag, ready, sram_addr, sram_dq_oe, sram_dq_out, sram_we_n, rdata);
    @(posedge clk);
    #1;
  endtask

  // LO and HI phases of one access, three cycles each.
  task automatic run_phases(input string tag, input logic wr, input logic [17:0] a_lo,
                            input logic [15:0] d_lo, input logic [15:0] d_hi);
    for (int i = 1; i <= 3; i++)
      cyc({tag, ".lo"}, 1'b0, a_lo, wr, wr ? d_lo : 16'h0, wr ? (i == 3) : 1'b1);
    for (int i = 1; i <= 3; i++)
      cyc({tag, ".hi"}, 1'b0, a_lo | 18'd1, wr, wr ? d_hi : 16'h0, wr ? (i == 3) : 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0;
    mem[6] = 16'h1111;
    mem[7] = 16'h2222;
    rst = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    address = 32'd0;
    wdata = 32'd0;

    // Reset state
    cyc("reset", 1'b1, 18'h0, 1'b0, 16'h0, 1'b1);
    chk("reset.rdata", rdata, 32'h0);
    rst = 1'b0;
    cyc("idle", 1'b1, 18'h0, 1'b0, 16'h0, 1'b1);

    // Write 0xDEADBEEF to 1032 (word 2), inputs scrambled after acceptance
    wr_en = 1'b1; address = 32'd1032; wdata = 32'hDEADBEEF;
    cyc("wr.c0", 1'b0, 18'h0, 1'b0, 16'h0, 1'b1);
    wr_en = 1'b0; address = 32'd0; wdata = 32'h0;
    run_phases("wr", 1'b1, 18'd4, 16'hBEEF, 16'hDEAD);
    cyc("wr.done", 1'b1, 18'h0, 1'b0, 16'h0, 1'b1);
    chk("wr.mem4", {16'd0, mem[4]}, 32'h0000BEEF);
    chk("wr.mem5", {16'd0, mem[5]}, 32'h0000DEAD);

    // Read it back
    rd_en = 1'b1; address = 32'd1032;
    cyc("rd.c0", 1'b0, 18'h0, 1'b0, 16'h0, 1'b1);
    rd_en = 1'b0; address = 32'd0;
    run_phases("rd", 1'b0, 18'd4, 16'h0, 16'h0);
    chk("rd.rdata_done", rdata, 32'hDEADBEEF);
    cyc("rd.done", 1'b1, 18'h0, 1'b0, 16'h0, 1'b1);

    // Both enables: write wins, rdata untouched
    wr_en = 1'b1; rd_en = 1'b1; address = 32'd1024; wdata = 32'h12345678;
    cyc("both.c0", 1'b0, 18'h0, 1'b0, 16'h0, 1'b1);
    wr_en = 1'b0; rd_en = 1'b0;
    run_phases("both", 1'b1, 18'd0, 16'h5678, 16'h1234);
    chk("both.rdata", rdata, 32'hDEADBEEF);
    cyc("both.done", 1'b1, 18'h0, 1'b0, 16'h0, 1'b1);
    chk("both.mem0", {16'd0, mem[0]}, 32'h00005678);
    chk("both.mem1", {16'd0, mem[1]}, 32'h00001234);

    // Request held through DONE: one access, then re-accepted in IDLE
    rd_en = 1'b1; address = 32'd1032;
    cyc("hold.c0", 1'b0, 18'h0, 1'b0, 16'h0, 1'b1);
    run_phases("hold", 1'b0, 18'd4, 16'h0, 16'h0);
    cyc("hold.done", 1'b1, 18'h0, 1'b0, 16'h0, 1'b1);
    cyc("hold.reacc", 1'b0, 18'h0, 1'b0, 16'h0, 1'b1);
    rd_en = 1'b0;
    run_phases("hold2", 1'b0, 18'd4, 16'h0, 16'h0);
    cyc("hold2.done", 1'b1, 18'h0, 1'b0, 16'h0, 1'b1);

    // Reset during the second HI cycle of a write
    wr_en = 1'b1; address = 32'd1032; wdata = 32'hCAFEF00D;
    cyc("rstw.c0", 1'b0, 18'h0, 1'b0, 16'h0, 1'b1);
    wr_en = 1'b0;
    for (int i = 1; i <= 3; i++)
      cyc("rstw.lo", 1'b0, 18'd4, 1'b1, 16'hF00D, (i == 3));
    cyc("rstw.hi1", 1'b0, 18'd5, 1'b1, 16'hCAFE, 1'b0);
    rst = 1'b1;
    #1;
    chk("rstw.we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rstw.oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("rstw.ready", {31'd0, ready}, 32'd1);
    chk("rstw.addr", {14'd0, sram_addr}, 32'd0);
    chk("rstw.rdata", rdata, 32'h0);
    $display("rstw.mid: ready=%b addr=%h oe=%b we_n=%b rdata=%h",
             ready, sram_addr, sram_dq_oe, sram_we_n, rdata);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("rstw.idle", 1'b1, 18'h0, 1'b0, 16'h0, 1'b1);
    rd_en = 1'b1; address = 32'd1032;
    cyc("rstr.c0", 1'b0, 18'h0, 1'b0, 16'h0, 1'b1);
    rd_en = 1'b0;
    run_phases("rstr", 1'b0, 18'd4, 16'h0, 16'h0);
    chk("rstr.rdata", rdata, 32'hCAFEF00D);
    cyc("rstr.done", 1'b1, 18'h0, 1'b0, 16'h0, 1'b1);

    // Address below DATA_BASE wraps to the top word
    rd_en = 1'b1; address = 32'd1020;
    cyc("wrap.c0", 1'b0, 18'h0, 1'b0, 16'h0, 1'b1);
    rd_en = 1'b0;
    run_phases("wrap", 1'b0, 18'h3FFFE, 16'h0, 16'h0);
    chk("wrap.rdata", rdata, 32'h22221111);
    cyc("wrap.done", 1'b1, 18'h0, 1'b0, 16'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
